// File: rtl/spi_reg_ctrl_if.sv
// Byte-level SPI slave link and register-bank bus shared by the command sequencer.
// The master side is the sequencer; the slave side is the SPI shifter plus register bank.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              cs_active;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic              tx_load;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        input  cs_active, rx_valid, rx_byte, reg_rdata,
        output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output cs_active, rx_valid, rx_byte, reg_rdata,
        input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Parses SPI chip-select frames (command byte + data/dummy bytes) into register
// write/read strobes with address auto-increment; read data is returned as tx bytes.
module spi_reg_ctrl #(
    parameter int         ADDR_W   = 7,
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] OOR_DATA = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_ctrl_if.master        bus,
    output logic                  busy,
    output logic [7:0]            err_cnt
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_WR       = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD       = 3'd5;

    localparam logic [ADDR_W:0] NUM_REGS_LIM = (ADDR_W+1)'(NUM_REGS);

    logic [2:0]        r_state;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_oor;
    logic [7:0]        r_tx_byte;
    logic              r_tx_load;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_we;
    logic              r_reg_re;
    logic [7:0]        r_err_cnt;

    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_issue_ok;
    logic              w_addr_ok;
    logic              w_go_issue;
    logic              w_wr_hit;
    logic              w_err_hit;

    assign w_cmd_addr   = bus.rx_byte[ADDR_W-1:0];
    // A read is issued either straight from the command byte or from a dummy byte.
    assign w_go_issue   = bus.cs_active && bus.rx_valid &&
                          (((r_state == S_CMD) && bus.rx_byte[7]) || (r_state == S_RD));
    assign w_issue_addr = (r_state == S_CMD) ? w_cmd_addr : r_addr;
    assign w_issue_ok   = {1'b0, w_issue_addr} < NUM_REGS_LIM;
    assign w_addr_ok    = {1'b0, r_addr} < NUM_REGS_LIM;
    assign w_wr_hit     = bus.cs_active && bus.rx_valid && (r_state == S_WR);
    assign w_err_hit    = (w_go_issue && !w_issue_ok) || (w_wr_hit && !w_addr_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_addr      <= '0;
            r_rd_oor    <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_load   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_reg_we  <= 1'b0;
            r_reg_re  <= 1'b0;
            r_tx_load <= 1'b0;
            if (w_err_hit && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            // Dropping CS aborts from any state; later pulses are simply never issued.
            if (!bus.cs_active) begin
                r_armed <= 1'b1;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_armed) begin
                            r_armed <= 1'b0;
                            r_state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (bus.rx_valid) begin
                            r_addr  <= w_cmd_addr;
                            r_state <= bus.rx_byte[7] ? S_RD_ISSUE : S_WR;
                        end
                    end
                    S_WR: begin
                        if (bus.rx_valid) begin
                            r_reg_we    <= w_addr_ok;
                            r_reg_wdata <= bus.rx_byte;
                            r_reg_addr  <= r_addr;
                            r_addr      <= r_addr + ADDR_W'(1);
                        end
                    end
                    S_RD_ISSUE: r_state <= S_RD_WAIT;
                    S_RD_WAIT: begin
                        r_tx_byte <= r_rd_oor ? OOR_DATA : bus.reg_rdata;
                        r_tx_load <= 1'b1;
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_state   <= S_RD;
                    end
                    S_RD: begin
                        if (bus.rx_valid) begin
                            r_state <= S_RD_ISSUE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
                if (w_go_issue) begin
                    r_reg_re   <= w_issue_ok;
                    r_reg_addr <= w_issue_addr;
                    r_rd_oor   <= !w_issue_ok;
                end
            end
        end
    end

    assign bus.tx_byte   = r_tx_byte;
    assign bus.tx_load   = r_tx_load;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_re    = r_reg_re;
    assign busy          = (r_state != S_IDLE);
    assign err_cnt       = r_err_cnt;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed frames for spi_reg_ctrl; expected strobes/tx bytes are queued by the
// stimulus and consumed by an independent monitor that also checks latencies.
module tb_spi_reg_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;

    spi_reg_ctrl_if #(.ADDR_W(7)) bus ();

    spi_reg_ctrl #(
        .ADDR_W   (7),
        .NUM_REGS (16),
        .OOR_DATA (8'hEE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Register bank model: synchronous write, read data one cycle after reg_re.
    logic [7:0] regs [0:127];
    always @(posedge clk) begin
        if (bus.reg_we) regs[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= regs[bus.reg_addr];
    end

    typedef struct {
        int kind;   // 0 = write strobe, 1 = read strobe, 2 = tx load
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   last_rx = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int addr, input int data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int addr, input int data);
        exp_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h, expected none", kind, addr, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                n_err++;
                $display("FAIL event: got kind=%0d addr=0x%0h data=0x%0h, expected kind=%0d addr=0x%0h data=0x%0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end else begin
                $display("ok  kind=%0d addr=0x%0h data=0x%0h at cycle %0d", kind, addr, data, cyc);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_we) begin
                chk("we_latency", cyc - last_rx, 1);
                pop_cmp(0, int'(bus.reg_addr), int'(bus.reg_wdata));
            end
            if (bus.reg_re) begin
                chk("re_latency", cyc - last_rx, 1);
                pop_cmp(1, int'(bus.reg_addr), 0);
            end
            if (bus.tx_load) begin
                chk("tx_latency", cyc - last_rx, 3);
                pop_cmp(2, 0, int'(bus.tx_byte));
            end
            if (bus.rx_valid && bus.cs_active) last_rx = cyc;
        end
    end

    task automatic cs_up();
        @(posedge clk);
        #1 bus.cs_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cs_down();
        repeat (6) @(posedge clk);
        #1 bus.cs_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit drop_cs);
        repeat (5) @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        if (drop_cs) bus.cs_active = 1'b0;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] bytes[$]);
        cs_up();
        foreach (bytes[i]) send(bytes[i], 1'b0);
        cs_down();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_byte"},   int'(bus.tx_byte),   0);
        chk({tag, "_tx_load"},   int'(bus.tx_load),   0);
        chk({tag, "_reg_addr"},  int'(bus.reg_addr),  0);
        chk({tag, "_reg_wdata"}, int'(bus.reg_wdata), 0);
        chk({tag, "_reg_we"},    int'(bus.reg_we),    0);
        chk({tag, "_reg_re"},    int'(bus.reg_re),    0);
        chk({tag, "_busy"},      int'(busy),          0);
        chk({tag, "_err_cnt"},   int'(err_cnt),       0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Preload registers 1 and 5..7 through ordinary write frames
        push(0, 1, 8'h5A);
        frame('{8'h01, 8'h5A});
        push(0, 5, 8'hA1); push(0, 6, 8'hB2); push(0, 7, 8'hC3);
        frame('{8'h05, 8'hA1, 8'hB2, 8'hC3});

        // Write burst
        push(0, 2, 8'h11); push(0, 3, 8'h22); push(0, 4, 8'h33);
        cs_up();
        @(negedge clk);
        chk("busy_in_frame", int'(busy), 1);
        send(8'h02, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        cs_down();
        chk("err_after_write", int'(err_cnt), 0);

        // Read burst from 5 with two dummies
        push(1, 5, 0); push(2, 0, 8'hA1);
        push(1, 6, 0); push(2, 0, 8'hB2);
        push(1, 7, 0); push(2, 0, 8'hC3);
        frame('{8'h85, 8'h00, 8'h00});

        // Write crossing the top of the implemented range
        push(0, 15, 8'h55);
        frame('{8'h0F, 8'h55, 8'h66});
        chk("err_after_oor_write", int'(err_cnt), 1);
        push(2, 0, 8'hEE);
        frame('{8'h90});
        chk("err_after_oor_read", int'(err_cnt), 2);
        push(1, 15, 0); push(2, 0, 8'h55); push(2, 0, 8'hEE);
        frame('{8'h8F, 8'h00});
        chk("err_after_cross_read", int'(err_cnt), 3);

        // Abort: CS drops together with the dummy byte
        push(1, 1, 0); push(2, 0, 8'h5A);
        cs_up();
        send(8'h81, 1'b0);
        send(8'h00, 1'b1);
        @(negedge clk);
        chk("busy_after_abort", int'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        // CS drop coincident with the command byte: nothing is parsed
        cs_up();
        send(8'h82, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        push(0, 3, 8'h44);
        frame('{8'h03, 8'h44});

        // Reset in the middle of a write frame
        push(0, 8, 8'h77);
        cs_up();
        send(8'h08, 1'b0);
        send(8'h77, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        send(8'h0A, 1'b0);
        send(8'h12, 1'b0);
        @(negedge clk);
        chk("busy_ignored_frame", int'(busy), 0);
        cs_down();
        push(0, 10, 8'h12);
        frame('{8'h0A, 8'h12});
        chk("err_after_reset", int'(err_cnt), 0);

        // Saturation: 3 frames x 100 writes to addresses 16..115
        for (int f = 0; f < 3; f++) begin
            cs_up();
            send(8'h10, 1'b0);
            for (int i = 0; i < 100; i++) send(8'(i), 1'b0);
            cs_down();
            if (f == 0) chk("err_after_100", int'(err_cnt), 100);
            if (f == 1) chk("err_after_200", int'(err_cnt), 200);
        end
        chk("err_saturated", int'(err_cnt), 8'hFF);

        repeat (10) @(posedge clk);
        #1;
        chk("pending_expected", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
